// File: rtl/cisr_row_accumulator_if.sv
// Beat stream from the CISR decoder and row-result stream toward vector write-back.
// The slave modport is the accumulator's view of both streams.
interface cisr_row_accumulator_if #(
   parameter int DATA_W = 32,
   parameter int DIM_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DIM_W-1:0]  in_row_idx;
   logic [DATA_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DIM_W-1:0]  out_row_idx;
   logic [DATA_W-1:0] out_sum;

   modport master (
      output in_valid, in_row_idx, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_row_idx, out_sum
   );

   modport slave (
      input  in_valid, in_row_idx, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_row_idx, out_sum
   );
endinterface

// File: rtl/cisr_row_accumulator.sv
// Per-channel row reduction: sums consecutive beats sharing a row index and queues
// one (row, sum) result per closed row in a small circular output FIFO.
module cisr_row_accumulator #(
   parameter int DATA_W    = 32,
   parameter int DIM_W     = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_spmv_init,
   cisr_row_accumulator_if.slave  bus,
   output logic                   o_done,
   output logic                   o_overflow
);
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DIM_W-1:0]  r_row_mem [OUT_DEPTH];
   logic [DATA_W-1:0] r_sum_mem [OUT_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic [DATA_W-1:0] r_acc;
   logic [DIM_W-1:0]  r_cur_row;
   logic              r_have_row;
   logic              r_pending_done;
   logic              r_done;
   logic              r_overflow;

   logic              w_accept;
   logic              w_same;
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_new_acc;
   logic              w_ovf;
   logic              w_push_old;
   logic              w_push_new;
   logic              w_pop;
   logic [CNT_W-1:0]  w_free;
   logic [CNT_W-1:0]  w_n_push;
   logic [CNT_W-1:0]  w_count_next;
   logic [PTR_W-1:0]  w_new_slot;

   // Two free slots are required so a row change and in_last can both push in one cycle.
   assign w_free       = CNT_W'(OUT_DEPTH) - r_count;
   assign bus.in_ready = !i_rst && !i_spmv_init && (w_free >= CNT_W'(2));
   assign w_accept     = bus.in_valid && bus.in_ready;

   assign w_same    = r_have_row && (bus.in_row_idx == r_cur_row);
   assign w_sum     = r_acc + bus.in_prod;
   assign w_new_acc = w_same ? w_sum : bus.in_prod;
   assign w_ovf     = w_accept && w_same
                      && (r_acc[DATA_W-1] == bus.in_prod[DATA_W-1])
                      && (w_sum[DATA_W-1] != r_acc[DATA_W-1]);

   assign w_push_old = w_accept && r_have_row && !w_same;
   assign w_push_new = w_accept && bus.in_last;
   assign w_pop      = (r_count != '0) && bus.out_ready;

   assign w_n_push     = CNT_W'(w_push_old) + CNT_W'(w_push_new);
   assign w_count_next = r_count + w_n_push - CNT_W'(w_pop);
   // The closing row takes the first slot; the in_last row lands right behind it.
   assign w_new_slot   = w_push_old ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;

   assign bus.out_valid   = (r_count != '0);
   assign bus.out_row_idx = r_row_mem[r_rd_ptr];
   assign bus.out_sum     = r_sum_mem[r_rd_ptr];
   assign o_done          = r_done;
   assign o_overflow      = r_overflow;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            r_row_mem[i] <= '0;
            r_sum_mem[i] <= '0;
         end
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_acc          <= '0;
         r_cur_row      <= '0;
         r_have_row     <= 1'b0;
         r_pending_done <= 1'b0;
         r_done         <= 1'b0;
         r_overflow     <= 1'b0;
      end else if (i_spmv_init) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            r_row_mem[i] <= '0;
            r_sum_mem[i] <= '0;
         end
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_acc          <= '0;
         r_cur_row      <= '0;
         r_have_row     <= 1'b0;
         r_pending_done <= 1'b0;
         r_done         <= 1'b0;
         r_overflow     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cur_row  <= bus.in_row_idx;
            r_acc      <= w_new_acc;
            r_have_row <= !bus.in_last;
         end

         if (w_push_old) begin
            r_row_mem[r_wr_ptr] <= r_cur_row;
            r_sum_mem[r_wr_ptr] <= r_acc;
         end
         if (w_push_new) begin
            r_row_mem[w_new_slot] <= bus.in_row_idx;
            r_sum_mem[w_new_slot] <= w_new_acc;
         end
         r_wr_ptr <= r_wr_ptr + w_n_push[PTR_W-1:0];
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_next;

         // done waits for the queue to drain; a fresh in_last re-arms it afterwards.
         r_done <= r_pending_done && (w_count_next == '0);
         if (r_pending_done && (w_count_next == '0))
            r_pending_done <= 1'b0;
         if (w_push_new)
            r_pending_done <= 1'b1;

         r_overflow <= r_overflow | w_ovf;
      end
   end
endmodule

// File: doc/cisr_row_accumulator.md
Name: cisr_row_accumulator

Overview:
- Per-channel reduction stage directly downstream of the CISR decoder.
- Consumes the channel's stream of (row index, partial product) beats and sums consecutive beats with the same row index.
- Emits one (row index, row sum) result per completed row through a valid/ready output FIFO toward vector write-back.
- One instance per channel, NUM_CH instances in the SpMV datapath.

Parameters:
DATA_W, 32, width of products and sums (two's complement)
OUT_DEPTH, 4, output FIFO depth in entries; minimum 2, power of two

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
spmv_init  input  1  synchronous clear at start of a new SpMV
in_valid  input  1  product beat valid
in_ready  output  1  stage can accept a beat
in_row_idx  input  `DIM_W  row index from decoder (row_idx_out of this channel)
in_prod  input  DATA_W  value*x partial product
in_last  input  1  beat is the final beat of this channel's stream
out_valid  output  1  result available at FIFO head
out_ready  input  1  downstream consumes result
out_row_idx  output  `DIM_W  row index of result
out_sum  output  DATA_W  row sum
done  output  1  one-cycle pulse: stream finished and all results drained
overflow  output  1  sticky: signed overflow occurred in any accumulation

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst). Outputs during and after reset: acc=0, cur_row=0, have_row=0, FIFO empty, out_valid=0, out_row_idx=0, out_sum=0, in_ready=0 while rst high, done=0, overflow=0, pending_done=0.
- spmv_init: synchronous, same clear as reset. in_ready=0 in that cycle; a beat presented in that cycle is not accepted. Takes priority over a beat and over a pop in the same cycle.
- in_ready = !rst && !spmv_init && (free FIFO slots >= 2). Two slots cover the worst case of two pushes in one cycle.
- Accept = in_valid && in_ready. On accept:
  - have_row=0: cur_row<=in_row_idx, acc<=in_prod, have_row<=1.
  - have_row=1 and in_row_idx==cur_row: acc<=acc+in_prod.
  - have_row=1 and in_row_idx!=cur_row: push (cur_row, acc); then cur_row<=in_row_idx, acc<=in_prod.
  - No ordering check: any differing index closes the row, including a lower index.
- in_last on an accepted beat: the beat is processed as above. The resulting open row (cur_row, new acc value) is then pushed in the same cycle, have_row<=0, pending_done<=1.
  - Up to two pushes per cycle; the older row is written first in FIFO order.
- Arithmetic: add wraps modulo 2^DATA_W. Signed overflow (operands same sign, result sign differs) sets overflow; it stays set until rst or spmv_init.
- Output FIFO: registered storage with circular read/write pointers and wrap-around.
  - out_valid = !empty. out_row_idx/out_sum always show the head entry.
  - Pop on out_valid && out_ready. Push and pop in the same cycle are allowed; the count is adjusted by pushes minus pops.
  - out_valid/out_row_idx/out_sum must hold stable while out_valid && !out_ready.
- Latency: a row result is visible at out_valid the cycle after the beat that closes it is accepted (row change, or in_last).
- done: pulses one cycle in the first cycle where pending_done=1 and the FIFO is empty after that cycle's pop. pending_done clears in the same cycle.
  - A stream whose last beat gets an empty FIFO immediately still takes at least one output cycle: done follows the final pop.
- Empty rows never produce output; gaps in the row index sequence are not filled.
- in_valid while in_ready=0: the beat is held by upstream and not consumed; no state change.

Test Plan:
- Single row: beats (row 3, 5),(3, 7),(3, -2, last), out_ready=1 -> one result (3, 10) one cycle after the last accept, done one cycle after the pop, overflow=0.
- Row changes: (0,1),(0,2),(4,10),(5,-3,last) -> results in order (0,3),(4,10),(5,-3). The last beat pushes (4,10) and (5,-3) in the same cycle.
- Backpressure: OUT_DEPTH=4, out_ready=0, beats on rows 0,1,2,3,... -> in_ready drops after 3 results are queued (2 free slots gone). Raising out_ready drains results in order and in_ready returns with no beat lost or duplicated.
- Overflow/wrap: DATA_W=32, (7, 0x7FFFFFFF),(7, 1, last) -> result (7, 0x80000000), overflow=1 and stays 1 until spmv_init clears it.
- spmv_init mid-stream with 2 results queued and an open row -> next cycle out_valid=0, overflow=0, no done. A new stream (9, 4, last) then yields (9, 4) only.
- Async reset asserted mid-cycle while out_valid=1 -> outputs clear immediately without a clock edge, in_ready=0 while rst is high.
